// File: rtl/matrix_shift_rx_pkg.sv
// rtl/matrix_shift_rx_pkg.sv - shared constants and CRC helper for matrix_shift_rx
package matrix_shift_rx_pkg;

    // Row tracker is a fixed 8-bit register; all-ones means "no row written yet".
    localparam int              TRK_W    = 8;
    localparam logic [TRK_W-1:0] ROW_NONE = '1;

    localparam int              FCNT_W   = 16;

    localparam logic [7:0]      CRC_POLY = 8'h07;
    localparam logic [7:0]      CRC_INIT = 8'h00;

    // One MSB-first CRC-8 step.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        crc8_step = {crc[6:0], 1'b0} ^ (((crc[7] ^ bit_in) == 1'b1) ? CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/matrix_shift_rx_pin_sync_edge.sv
// rtl/matrix_shift_rx_pin_sync_edge.sv - pin synchroniser with rising-edge pulse
//
// Ports:
//   clock, resetb : system clock, asynchronous active-low reset
//   i_pin         : asynchronous input pin
//   o_level       : synchronised level (SYNC_STAGES flops deep)
//   o_rise        : one-cycle pulse when o_level goes 0 -> 1
// SYNC_STAGES must be at least 2.
module pin_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic resetb,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/matrix_shift_rx.sv
// rtl/matrix_shift_rx.sv - LED-matrix shift-register receiver with double-buffered frame store
//
// Ports:
//   clock, resetb                  : system clock, asynchronous active-low reset
//   rclk/rsdi, cclk/csdi, le, oeb  : asynchronous matrix interface pins
//   row_q, col_q                   : latched row/column patterns, zero while oeb is high
//   rd_addr, rd_data               : display-buffer read port, 1-cycle latency
//   frame_done, frame_count        : frame completion pulse and wrapping 16-bit count
//   err_multirow, err_overrun      : sticky error flags
//   frame_crc, crc_valid           : CRC-8 of each completed frame (MATRIX_SHIFT_RX_CRC_EN only)
// Optional feature macro: MATRIX_SHIFT_RX_CRC_EN
module matrix_shift_rx
    import matrix_shift_rx_pkg::*;
#(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic                     rclk,
    input  logic                     rsdi,
    input  logic                     cclk,
    input  logic                     csdi,
    input  logic                     le,
    input  logic                     oeb,
    output logic [ROWS-1:0]          row_q,
    output logic [COLS-1:0]          col_q,
    input  logic [$clog2(ROWS)-1:0]  rd_addr,
    output logic [COLS-1:0]          rd_data,
    output logic                     frame_done,
    output logic [FCNT_W-1:0]        frame_count,
    output logic                     err_multirow,
    output logic                     err_overrun
`ifdef MATRIX_SHIFT_RX_CRC_EN
    ,
    output logic [7:0]               frame_crc,
    output logic                     crc_valid
`endif
);

    localparam int IDX_W  = $clog2(ROWS);
    localparam int RCNT_W = $clog2(ROWS + 2);
    localparam int CCNT_W = $clog2(COLS + 2);
    localparam logic [RCNT_W-1:0] RCNT_MAX = RCNT_W'(ROWS + 1);
    localparam logic [CCNT_W-1:0] CCNT_MAX = CCNT_W'(COLS + 1);

    // Pin order: 0 rclk, 1 rsdi, 2 cclk, 3 csdi, 4 le, 5 oeb
    logic [5:0] w_pin;
    logic [5:0] w_lvl;
    logic [5:0] w_rise;
    logic       w_unused_sync;

    assign w_pin = {oeb, le, csdi, cclk, rsdi, rclk};

    for (genvar g = 0; g < 6; g++) begin : g_sync
        pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clock   (clock),
            .resetb  (resetb),
            .i_pin   (w_pin[g]),
            .o_level (w_lvl[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign w_unused_sync = ^{w_lvl[0], w_lvl[2], w_lvl[4], w_rise[1], w_rise[3], w_rise[5]};

    logic [ROWS-1:0]   r_rsh, r_row_l;
    logic [COLS-1:0]   r_csh, r_col_l;
    logic [RCNT_W-1:0] r_rcnt;
    logic [CCNT_W-1:0] r_ccnt;
    logic [TRK_W-1:0]  r_trk;
    logic              r_sel;
    logic [COLS-1:0]   r_bank0 [ROWS];
    logic [COLS-1:0]   r_bank1 [ROWS];
    logic [COLS-1:0]   r_rd_data;
    logic              r_frame_done;
    logic [FCNT_W-1:0] r_frame_count;
    logic              r_err_multirow;
    logic              r_err_overrun;

    logic [ROWS-1:0]   w_rsh_nxt;
    logic [COLS-1:0]   w_csh_nxt;
    logic [RCNT_W-1:0] w_rcnt_nxt;
    logic [CCNT_W-1:0] w_ccnt_nxt;
    logic [IDX_W-1:0]  w_idx;
    logic              w_onehot;
    logic              w_multi;
    logic              w_latch;
    logic              w_complete;
    logic              w_wr_bank;

    // The latch sees post-shift chain contents, so a coincident shift edge is included.
    always_comb begin
        w_rsh_nxt  = w_rise[0] ? {r_rsh[ROWS-2:0], w_lvl[1]} : r_rsh;
        w_csh_nxt  = w_rise[2] ? {r_csh[COLS-2:0], w_lvl[3]} : r_csh;
        w_rcnt_nxt = (w_rise[0] && (r_rcnt != RCNT_MAX)) ? r_rcnt + 1'b1 : r_rcnt;
        w_ccnt_nxt = (w_rise[2] && (r_ccnt != CCNT_MAX)) ? r_ccnt + 1'b1 : r_ccnt;
        w_idx      = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (w_rsh_nxt[i]) begin
                w_idx = IDX_W'(i);
            end
        end
        w_onehot   = (w_rsh_nxt != '0) && ((w_rsh_nxt & (w_rsh_nxt - ROWS'(1))) == '0);
        w_multi    = (w_rsh_nxt != '0) && !w_onehot;
        w_latch    = w_rise[4];
        w_complete = w_latch && w_onehot && (w_idx == '0) && (r_trk == TRK_W'(ROWS - 1));
        // The completing row-0 write lands in the bank that is about to become the write bank.
        w_wr_bank  = w_complete ? r_sel : ~r_sel;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_rsh          <= '0;
            r_csh          <= '0;
            r_row_l        <= '0;
            r_col_l        <= '0;
            r_rcnt         <= '0;
            r_ccnt         <= '0;
            r_trk          <= ROW_NONE;
            r_sel          <= 1'b0;
            r_rd_data      <= '0;
            r_frame_done   <= 1'b0;
            r_frame_count  <= '0;
            r_err_multirow <= 1'b0;
            r_err_overrun  <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                r_bank0[i] <= '0;
                r_bank1[i] <= '0;
            end
        end else begin
            r_rsh        <= w_rsh_nxt;
            r_csh        <= w_csh_nxt;
            r_rcnt       <= w_latch ? '0 : w_rcnt_nxt;
            r_ccnt       <= w_latch ? '0 : w_ccnt_nxt;
            r_frame_done <= w_complete;
            if ((w_rcnt_nxt == RCNT_MAX) || (w_ccnt_nxt == CCNT_MAX)) begin
                r_err_overrun <= 1'b1;
            end
            if (w_latch) begin
                r_row_l <= w_rsh_nxt;
                r_col_l <= w_csh_nxt;
                if (w_onehot) begin
                    r_trk <= TRK_W'(w_idx);
                    if (w_wr_bank) begin
                        r_bank1[w_idx] <= w_csh_nxt;
                    end else begin
                        r_bank0[w_idx] <= w_csh_nxt;
                    end
                end
                if (w_multi) begin
                    r_err_multirow <= 1'b1;
                end
            end
            if (w_complete) begin
                r_sel         <= ~r_sel;
                r_frame_count <= r_frame_count + 1'b1;
            end
            if (int'(rd_addr) < ROWS) begin
                r_rd_data <= r_sel ? r_bank1[rd_addr] : r_bank0[rd_addr];
            end else begin
                r_rd_data <= '0;
            end
        end
    end

    assign row_q        = r_row_l & {ROWS{~w_lvl[5]}};
    assign col_q        = r_col_l & {COLS{~w_lvl[5]}};
    assign rd_data      = r_rd_data;
    assign frame_done   = r_frame_done;
    assign frame_count  = r_frame_count;
    assign err_multirow = r_err_multirow;
    assign err_overrun  = r_err_overrun;

`ifdef MATRIX_SHIFT_RX_CRC_EN
    localparam int CIDX_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic [IDX_W-1:0]  r_crc_row;
    logic [CIDX_W-1:0] r_crc_col;
    logic              r_crc_busy;
    logic [7:0]        r_crc;
    logic [7:0]        r_frame_crc;
    logic              r_crc_valid;
    logic              w_crc_bit;
    logic [7:0]        w_crc_nxt;

    // Walks the new display bank (sel has already toggled) row by row, MSB first.
    always_comb begin
        w_crc_bit = r_sel ? r_bank1[r_crc_row][r_crc_col] : r_bank0[r_crc_row][r_crc_col];
        w_crc_nxt = crc8_step(r_crc, w_crc_bit);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_crc_row   <= '0;
            r_crc_col   <= '0;
            r_crc_busy  <= 1'b0;
            r_crc       <= CRC_INIT;
            r_frame_crc <= '0;
            r_crc_valid <= 1'b0;
        end else begin
            r_crc_valid <= 1'b0;
            if (w_complete) begin
                r_crc_busy <= 1'b1;
                r_crc_row  <= '0;
                r_crc_col  <= CIDX_W'(COLS - 1);
                r_crc      <= CRC_INIT;
            end else if (r_crc_busy) begin
                r_crc <= w_crc_nxt;
                if (r_crc_col == '0) begin
                    r_crc_col <= CIDX_W'(COLS - 1);
                    if (r_crc_row == IDX_W'(ROWS - 1)) begin
                        r_crc_busy  <= 1'b0;
                        r_frame_crc <= w_crc_nxt;
                        r_crc_valid <= 1'b1;
                    end else begin
                        r_crc_row <= r_crc_row + 1'b1;
                    end
                end else begin
                    r_crc_col <= r_crc_col - 1'b1;
                end
            end
        end
    end

    assign frame_crc = r_frame_crc;
    assign crc_valid = r_crc_valid;
`endif

endmodule
